// File: rtl/elephant_ise_v3_if.sv
`default_nettype none
// ============================================================================
// Module      : elephant_ise_v3_if
// Description : Request/result handshake bundle between the RV32 core's
//               multi-cycle functional-unit port and the Elephant ISE
//               datapath.
//               master : core side. Drives the request fields and out_ready.
//               slave  : datapath side. Drives in_ready, out_valid and rd.
// Signals     : in_valid/in_ready     request handshake
//               op[1:0]               00 bsllxor, 01 bup, 10 pstep1, 11 pinv1
//               rs1, rs2 [XLEN-1:0]   source operands
//               imm[4:0]              immediate shift / bit index
//               out_valid/out_ready   result handshake
//               rd [XLEN-1:0]         result
// Revision    : 1.0 - initial release
// ============================================================================
interface elephant_ise_v3_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;

    modport master (
        output in_valid, op, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, rd
    );

    modport slave (
        input  in_valid, op, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, rd
    );
endinterface
`default_nettype wire

// File: rtl/elephant_ise_v3.sv
`default_nettype none
// ============================================================================
// Module      : elephant_ise_v3
// Description : Elephant (Spongent-pi) ISE datapath. Single-cycle bsllxor and
//               bup, plus the pstep1 / pinv1 swapmove chain which is spread
//               over 4/SWM_PER_CYCLE iteration cycles. The result sits in a
//               single-entry register until the consumer drains it.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - elephant_ise_v3_if.slave (request + result handshake)
// Parameters  : SWM_PER_CYCLE - swapmove stages per cycle (1, 2 or 4)
//               XLEN          - datapath width (32 only)
// Revision    : 1.0 - initial release
// ============================================================================
module elephant_ise_v3 #(
    parameter int SWM_PER_CYCLE = 4,
    parameter int XLEN          = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    elephant_ise_v3_if.slave  bus
);

    generate
        if (!(SWM_PER_CYCLE == 1 || SWM_PER_CYCLE == 2 || SWM_PER_CYCLE == 4)) begin : g_bad_swm
            $error("elephant_ise_v3: SWM_PER_CYCLE must be 1, 2 or 4");
        end
        if (XLEN != 32) begin : g_bad_xlen
            $error("elephant_ise_v3: XLEN must be 32");
        end
    endgenerate

    localparam logic [0:0]  c_IDLE     = 1'b0;
    localparam logic [0:0]  c_ITER     = 1'b1;
    // Number of ITER edges is 4/SWM_PER_CYCLE; the counter exits on its last value.
    localparam logic [1:0]  c_CNT_LAST = 2'(4 / SWM_PER_CYCLE - 1);
    // Stage offset per iteration. For SWM_PER_CYCLE=4 this truncates to 0,
    // which is harmless because the counter never leaves 0 in that case.
    localparam logic [1:0]  c_SPC2     = 2'(SWM_PER_CYCLE);
    localparam logic [31:0] c_M0       = 32'h0A0A_0A0A;
    localparam logic [31:0] c_M1       = 32'h00CC_00CC;
    localparam logic [31:0] c_M2       = 32'h0000_F0F0;
    localparam logic [31:0] c_M3       = 32'h0000_00FF;

    function automatic logic [31:0] swm(input logic [31:0] x, input int a, input logic [31:0] m);
        logic [31:0] t;
        t = (x ^ (x >> a)) & m;
        return x ^ t ^ (t << a);
    endfunction

    function automatic logic [31:0] stage(input logic [31:0] x, input logic [1:0] s);
        logic [31:0] r;
        case (s)
            2'd0:    r = swm(x, 3,  c_M0);
            2'd1:    r = swm(x, 6,  c_M1);
            2'd2:    r = swm(x, 12, c_M2);
            default: r = swm(x, 24, c_M3);
        endcase
        return r;
    endfunction

    // One iteration: stages cnt*SPC .. cnt*SPC+SPC-1 of the chain. The inverse
    // direction walks the list backwards, i.e. stage index 3-g == ~g.
    function automatic logic [31:0] iter_step(input logic [31:0] x, input logic [1:0] cnt,
                                              input logic dir);
        logic [31:0] y;
        logic [1:0]  g;
        y = x;
        for (int j = 0; j < SWM_PER_CYCLE; j++) begin
            g = cnt * c_SPC2 + 2'(j);
            y = stage(y, dir ? ~g : g);
        end
        return y;
    endfunction

    logic [0:0]  r_state;
    logic [1:0]  r_cnt;
    logic        r_dir;
    logic [31:0] r_work;
    logic [31:0] r_rd;
    logic        r_out_valid;

    logic        w_in_ready;
    logic        w_accept;
    logic [4:0]  w_bup_sh;
    logic [31:0] w_bsllxor;
    logic [31:0] w_bup;
    logic [31:0] w_single;
    logic [31:0] w_step;
    logic        w_unused_rs2_hi;

    // rst gates in_ready directly so nothing is accepted while reset is held.
    assign w_in_ready = ~rst & (r_state == c_IDLE) & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    // 5-bit subtraction wraps modulo 32 by construction.
    assign w_bup_sh   = bus.imm - bus.rs2[4:0];
    assign w_bsllxor  = bus.rs1 ^ ({24'd0, bus.rs2[7:0]} << bus.imm);
    assign w_bup      = (bus.rs1 << w_bup_sh) & (32'd1 << bus.imm);
    assign w_single   = bus.op[0] ? w_bup : w_bsllxor;
    assign w_step     = iter_step(r_work, r_cnt, r_dir);

    assign w_unused_rs2_hi = ^bus.rs2[31:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 2'd0;
            r_dir       <= 1'b0;
            r_work      <= 32'd0;
            r_rd        <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (!bus.op[1]) begin
                            r_rd        <= w_single;
                            r_out_valid <= 1'b1;
                        end else begin
                            // Entry requires an empty or draining result slot.
                            r_work      <= bus.rs1;
                            r_cnt       <= 2'd0;
                            r_dir       <= bus.op[0];
                            r_out_valid <= 1'b0;
                            r_state     <= c_ITER;
                        end
                    end else if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                c_ITER: begin
                    r_work <= w_step;
                    if (r_cnt == c_CNT_LAST) begin
                        r_rd        <= w_step;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 2'd0;
                        r_state     <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.rd        = r_rd;

endmodule
`default_nettype wire
